// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - beat sequencer and accumulator for the external 4-lane 8-bit MAC
// Define MAC_SEQ_SAT_EN for a saturating accumulator with a sticky res_ovf flag.
module mac_seq_ctrl #(
   parameter int CNT_W = 8,
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_beats,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   output logic [31:0]      mac_a_out,
   output logic [31:0]      mac_b_out,
   input  logic [15:0]      mac_result_in,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] res_data,
   output logic             res_ovf,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_remaining;
   logic             r_pipe_valid;
   logic [ACC_W-1:0] r_acc;
   logic             r_cmd_ready;
   logic             r_in_ready;
   logic             r_res_valid;
   logic             r_busy;
   logic [31:0]      r_mac_a;
   logic [31:0]      r_mac_b;

   logic             w_beat;
   logic [ACC_W-1:0] w_add;
   logic [ACC_W-1:0] w_acc_next;

   assign w_beat = in_valid & r_in_ready;
   assign w_add  = ACC_W'(mac_result_in);

`ifdef MAC_SEQ_SAT_EN
   logic [ACC_W:0] w_sum;
   logic           r_ovf;
   assign w_sum      = {1'b0, r_acc} + {1'b0, w_add};
   assign w_acc_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
   assign res_ovf    = r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (r_state == S_IDLE && cmd_valid) begin
         r_ovf <= 1'b0;
      end else if (r_pipe_valid && w_sum[ACC_W]) begin
         r_ovf <= 1'b1;
      end
   end
`else
   assign w_acc_next = r_acc + w_add;
   assign res_ovf    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_remaining  <= '0;
         r_pipe_valid <= 1'b0;
         r_acc        <= '0;
         r_cmd_ready  <= 1'b1;
         r_in_ready   <= 1'b0;
         r_res_valid  <= 1'b0;
         r_busy       <= 1'b0;
         r_mac_a      <= '0;
         r_mac_b      <= '0;
      end else begin
         // Product of the beat registered last cycle is on mac_result_in now.
         r_pipe_valid <= w_beat;
         if (r_pipe_valid) begin
            r_acc <= w_acc_next;
         end
         if (w_beat) begin
            r_mac_a <= in_a;
            r_mac_b <= in_b;
         end
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_remaining <= cmd_beats;
                  r_acc       <= '0;
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (cmd_beats != '0) begin
                     r_state    <= S_RUN;
                     r_in_ready <= 1'b1;
                  end else begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_RUN: begin
               if (w_beat) begin
                  r_remaining <= r_remaining - CNT_W'(1);
                  if (r_remaining == CNT_W'(1)) begin
                     r_state    <= S_DRAIN;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            S_DRAIN: begin
               r_state     <= S_DONE;
               r_res_valid <= 1'b1;
            end
            S_DONE: begin
               if (res_ready) begin
                  r_state     <= S_IDLE;
                  r_res_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign in_ready  = r_in_ready;
   assign res_valid = r_res_valid;
   assign res_data  = r_acc;
   assign busy      = r_busy;
   assign mac_a_out = r_mac_a;
   assign mac_b_out = r_mac_b;

endmodule
